// File: rtl/led_shift_if.sv
// LED shifter control/status bundle.
// master drives controls, slave returns the pattern and status.
interface led_shift_if #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 24
);
  logic             load;
  logic [WIDTH-1:0] pattern;
  logic             start;
  logic             pause;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_max;
  logic [WIDTH-1:0] led;
  logic [1:0]       state;
  logic             step;
  logic             wrap;

  modport master (
    output load, pattern, start, pause, mode, div_max,
    input  led, state, step, wrap
  );

  modport slave (
    input  load, pattern, start, pause, mode, div_max,
    output led, state, step, wrap
  );
endinterface

// File: rtl/led_shift_ctrl.sv
// Prescaled LED pattern shifter: rotate right/left, bounce, hold.
// IDLE/RUN/PAUSE control with registered step and wrap pulses.
module led_shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 24
) (
  input logic       clk,
  input logic       rst,
  led_shift_if.slave bus
);
  localparam int PW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] rotr, rotl;

  assign rotr = {led_q[0], led_q[WIDTH-1:1]};
  assign rotl = {led_q[WIDTH-2:0], led_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    presc_d = presc_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (bus.load) begin
      state_d = S_IDLE;
      led_d   = bus.pattern;
      presc_d = '0;
      pos_d   = '0;
      dir_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          presc_d = '0;
          if (bus.start && !bus.pause)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.pause) begin
            state_d = S_PAUSE;
          end else if (presc_q < bus.div_max) begin
            presc_d = presc_q + 1'b1;
          end else begin
            presc_d = '0;
            step_d  = 1'b1;
            unique case (bus.mode)
              2'b00, 2'b01: begin
                led_d = bus.mode[0] ? rotl : rotr;
                if (pos_q == LAST) begin
                  pos_d  = '0;
                  wrap_d = 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                end
              end
              2'b10: begin
                // dir_q: 0 = moving right, 1 = moving left
                if (!dir_q && led_q[0]) begin
                  dir_d  = 1'b1;
                  led_d  = rotl;
                  wrap_d = 1'b1;
                end else if (dir_q && led_q[WIDTH-1]) begin
                  dir_d  = 1'b0;
                  led_d  = rotr;
                  wrap_d = 1'b1;
                end else begin
                  led_d = dir_q ? rotl : rotr;
                end
              end
              default: led_d = led_q;
            endcase
          end
        end
        S_PAUSE: begin
          if (bus.start && !bus.pause)
            state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      led_q   <= '0;
      presc_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.led   = led_q;
  assign bus.state = state_q;
  assign bus.step  = step_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_led_shift_ctrl.sv
// Directed bench for led_shift_ctrl.
// Expectations queued with stimulus, popped and asserted after each edge.
module tb_led_shift_ctrl;
  localparam int W  = 4;
  localparam int DW = 24;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] PAUS = 2'b10;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  string tag_q[$];

  led_shift_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  led_shift_ctrl #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [3:0] l,
                      input logic [1:0] s, input logic st,
                      input logic w);
    exp_q.push_back({l, s, st, w});
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp();
    logic [7:0] e;
    logic [7:0] o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {bus.led, bus.state, bus.step, bus.wrap};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed{led,state,step,wrap}=%b expected=%b",
             t, o, e);
    end
  endtask

  task automatic tick(input string tag, input logic [3:0] l,
                      input logic [1:0] s, input logic st,
                      input logic w);
    push(tag, l, s, st, w);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic now(input string tag, input logic [3:0] l,
                     input logic [1:0] s, input logic st,
                     input logic w);
    push(tag, l, s, st, w);
    pop_cmp();
  endtask

  initial begin
    rst = 1'b1;
    bus.load = 1'b0;
    bus.pattern = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.mode = 2'b00;
    bus.div_max = '0;
    #1;
    now("reset_async", 4'b0000, IDLE, 1'b0, 1'b0);
    tick("reset_hold", 4'b0000, IDLE, 1'b0, 1'b0);
    rst = 1'b0;

    // rotate right, div 0
    bus.load = 1'b1;
    bus.pattern = 4'b0001;
    tick("rr_load", 4'b0001, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick("rr_enter", 4'b0001, RUN, 1'b0, 1'b0);
    tick("rr_s1", 4'b1000, RUN, 1'b1, 1'b0);
    tick("rr_s2", 4'b0100, RUN, 1'b1, 1'b0);
    tick("rr_s3", 4'b0010, RUN, 1'b1, 1'b0);
    tick("rr_s4", 4'b0001, RUN, 1'b1, 1'b1);

    // rotate left, div 3, pause/resume
    bus.load = 1'b1;
    bus.start = 1'b0;
    bus.mode = 2'b01;
    bus.div_max = 24'd3;
    tick("rl_load", 4'b0001, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick("rl_enter", 4'b0001, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("rl_wait0", 4'b0001, RUN, 1'b0, 1'b0);
    tick("rl_s1", 4'b0010, RUN, 1'b1, 1'b0);
    tick("rl_cnt1", 4'b0010, RUN, 1'b0, 1'b0);
    bus.pause = 1'b1;
    for (int i = 0; i < 4; i++)
      tick("rl_paused", 4'b0010, PAUS, 1'b0, 1'b0);
    bus.pause = 1'b0;
    tick("rl_resume", 4'b0010, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++)
      tick("rl_remain", 4'b0010, RUN, 1'b0, 1'b0);
    tick("rl_s2", 4'b0100, RUN, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("rl_wait2", 4'b0100, RUN, 1'b0, 1'b0);
    tick("rl_s3", 4'b1000, RUN, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("rl_wait3", 4'b1000, RUN, 1'b0, 1'b0);
    tick("rl_s4", 4'b0001, RUN, 1'b1, 1'b1);

    // bounce
    bus.load = 1'b1;
    bus.start = 1'b0;
    bus.pattern = 4'b0010;
    bus.mode = 2'b10;
    bus.div_max = '0;
    tick("bn_load", 4'b0010, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    bus.start = 1'b1;
    tick("bn_enter", 4'b0010, RUN, 1'b0, 1'b0);
    tick("bn_s1", 4'b0001, RUN, 1'b1, 1'b0);
    tick("bn_s2", 4'b0010, RUN, 1'b1, 1'b1);
    tick("bn_s3", 4'b0100, RUN, 1'b1, 1'b0);
    tick("bn_s4", 4'b1000, RUN, 1'b1, 1'b0);
    tick("bn_s5", 4'b0100, RUN, 1'b1, 1'b1);
    tick("bn_s6", 4'b0010, RUN, 1'b1, 1'b0);

    // load > pause > start priority
    bus.load = 1'b1;
    bus.pause = 1'b1;
    bus.pattern = 4'b1010;
    tick("prio_load", 4'b1010, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick("prio_idle", 4'b1010, IDLE, 1'b0, 1'b0);
    bus.pause = 1'b0;
    tick("prio_run", 4'b1010, RUN, 1'b0, 1'b0);
    tick("prio_s1", 4'b0101, RUN, 1'b1, 1'b0);
    tick("prio_s2", 4'b1010, RUN, 1'b1, 1'b1);

    // async reset mid-RUN, then run from zero
    bus.mode = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    now("rst_mid", 4'b0000, IDLE, 1'b0, 1'b0);
    tick("rst_held", 4'b0000, IDLE, 1'b0, 1'b0);
    rst = 1'b0;
    tick("z_enter", 4'b0000, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("z_step", 4'b0000, RUN, 1'b1, 1'b0);
    tick("z_wrap", 4'b0000, RUN, 1'b1, 1'b1);

    // hold mode, div 1
    bus.load = 1'b1;
    bus.pattern = 4'b0110;
    bus.mode = 2'b11;
    bus.div_max = 24'd1;
    tick("hd_load", 4'b0110, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick("hd_enter", 4'b0110, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick("hd_wait", 4'b0110, RUN, 1'b0, 1'b0);
      tick("hd_step", 4'b0110, RUN, 1'b1, 1'b0);
    end

    // lowering div_max below count, then mode change
    bus.load = 1'b1;
    bus.pattern = 4'b0001;
    bus.mode = 2'b00;
    bus.div_max = 24'd5;
    tick("dv_load", 4'b0001, IDLE, 1'b0, 1'b0);
    bus.load = 1'b0;
    tick("dv_enter", 4'b0001, RUN, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      tick("dv_cnt", 4'b0001, RUN, 1'b0, 1'b0);
    bus.div_max = 24'd1;
    tick("dv_lower", 4'b1000, RUN, 1'b1, 1'b0);
    bus.mode = 2'b01;
    bus.div_max = '0;
    tick("mc_s1", 4'b0001, RUN, 1'b1, 1'b0);
    tick("mc_s2", 4'b0010, RUN, 1'b1, 1'b0);
    tick("mc_s3", 4'b0100, RUN, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_shift_ctrl.md
LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, width of the LED pattern register (WIDTH >= 2).
REQ-002 Parameter DIV_W, default 24, width of the step prescaler.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 load  input  1  single-cycle strobe: capture pattern and return to IDLE.
REQ-006 pattern  input  WIDTH  value captured on load.
REQ-007 start  input  1  level; enter or resume RUN.
REQ-008 pause  input  1  level; freeze stepping while in RUN.
REQ-009 mode  input  2  00 rotate right, 01 rotate left, 10 bounce, 11 hold (no movement).
REQ-010 div_max  input  DIV_W  step period minus one, in clk cycles; sampled every cycle.
REQ-011 led  output  WIDTH  registered pattern driving the LEDs.
REQ-012 state  output  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE.
REQ-013 step  output  1  registered one-cycle pulse, high in the cycle after led moved.
REQ-014 wrap  output  1  registered one-cycle pulse marking a full rotation or bounce reversal.

Function
REQ-015 FSM transitions SHALL be: IDLE->RUN on start; RUN->PAUSE on pause; PAUSE->RUN on start with pause low; load from any state -> IDLE.
REQ-016 Same-cycle priority SHALL be load > pause > start; start and pause both high in IDLE or PAUSE leaves the state unchanged.
REQ-017 On load: led <= pattern, prescaler <= 0, position counter <= 0, direction <= right, step/wrap low next cycle.
REQ-018 Prescaler SHALL count only in RUN; when prescaler >= div_max a step event occurs and prescaler <= 0, else prescaler increments.
REQ-019 div_max = 0 SHALL produce a step event every RUN cycle; lowering div_max below the current count causes a step on the next RUN cycle.
REQ-020 In IDLE the prescaler SHALL be held at 0; in PAUSE it SHALL hold its value and resume from it on return to RUN.
REQ-021 Rotate right step: led <= {led[0], led[WIDTH-1:1]}; rotate left step: led <= {led[WIDTH-2:0], led[WIDTH-1]}.
REQ-022 Bounce step: if direction = right and led[0] = 1, direction <= left and rotate left; if direction = left and led[WIDTH-1] = 1, direction <= right and rotate right; otherwise rotate in current direction.
REQ-023 Hold mode: step events still pulse step, led unchanged, no wrap.
REQ-024 Position counter 0..WIDTH-1 SHALL increment on each rotate-mode step and wrap to 0; wrap SHALL pulse on the step where it wraps from WIDTH-1 to 0.
REQ-025 In bounce mode wrap SHALL pulse on each step that reverses direction; position counter unchanged.
REQ-026 A mode change SHALL take effect on the next step event without clearing led, prescaler, or position counter; direction is retained.
REQ-027 All-zero or all-one patterns SHALL step normally (all-one in bounce reverses every step).
REQ-028 step and wrap SHALL be low in every cycle without a step event, including the load cycle.

Reset
REQ-029 While rst is high: led = 0, state = IDLE, prescaler = 0, position = 0, direction = right, step = 0, wrap = 0, asynchronously.
REQ-030 Deassertion of rst SHALL resume normal operation on the first clk edge; reset mid-RUN discards all progress.

Verification
REQ-031 WIDTH=4, load pattern=4'b0001, mode=00, div_max=0, start -> led 1000, 0100, 0010, 0001 on consecutive cycles; wrap high with the fourth step.
REQ-032 div_max=3, RUN, mode=01 from 0001 -> step every 4th cycle, led 0010, 0100, 1000, 0001; assert pause after first step -> led frozen, prescaler held; start -> next step after remaining count.
REQ-033 Bounce from 0010, direction right, div_max=0 -> led 0001, 0010 (wrap), 0100, 1000, 0100 (wrap), 0010.
REQ-034 load=1, pause=1, start=1 same cycle in RUN -> state IDLE, led = pattern, step=0.
REQ-035 rst asserted mid-RUN between clock edges -> led=0, state=IDLE immediately; after release, start with no load -> steps rotate 0000, step still pulses.
REQ-036 mode=11 in RUN, div_max=1 -> step pulses every 2nd cycle, led constant, wrap never asserted.
